mu02_core: RTL

Parametrised successor to the classroom accumulator processor (MU01). It is a multi-cycle accumulator CPU that executes the same 4-bit-opcode ISA plus AND, OR, JLT and illegal-opcode trapping. It has configurable data and address widths and a run/halt control. Instructions and data live in an external memory reached through a req/ack handshake with arbitrary wait states, which replaces the internal array and lets the core share memory with a loader or bus.

---
 rtl/mu02_pkg.sv | 44 ++++
 rtl/mu02_alu.sv | 37 +++
 rtl/mu02_core.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mu02_pkg.sv
// Shared definitions for the mu02 accumulator core: opcodes, FSM states and decode helpers.
package mu02_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDA  = 4'b0000;
  localparam logic [3:0] OP_STO  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_JMP  = 4'b0100;
  localparam logic [3:0] OP_JGE  = 4'b0101;
  localparam logic [3:0] OP_JNE  = 4'b0110;
  localparam logic [3:0] OP_STP  = 4'b0111;
  localparam logic [3:0] OP_LDAI = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_ADDI = 4'b1010;
  localparam logic [3:0] OP_SUBI = 4'b1011;
  localparam logic [3:0] OP_JLT  = 4'b1100;
  localparam logic [3:0] OP_OR   = 4'b1101;

  localparam int SEXT_W = 64;

  // Sign-extends the low w bits of v; callers narrow the result to their data width.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int unsigned w);
    logic [SEXT_W-1:0] sh;
    sh = v << (SEXT_W - w);
    return $unsigned($signed(sh) >>> (SEXT_W - w));
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_STO) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op[3:1] == 3'b111;
  endfunction

endpackage

// File: rtl/mu02_alu.sv
// Combinational ALU for mu02: picks memory word or immediate and produces the new acc and carry.
module mu02_alu
  import mu02_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] mval,
  input  logic [DATA_W-1:0] imm,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  logic [DATA_W-1:0] b;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  always_comb begin
    b    = (op == OP_LDAI || op == OP_ADDI || op == OP_SUBI) ? imm : mval;
    sum  = {1'b0, acc} + {1'b0, b};
    // Top bit of the widened difference is the borrow.
    diff = {1'b0, acc} - {1'b0, b};
    result    = acc;
    carry_out = carry_in;
    case (op)
      OP_LDA, OP_LDAI: result = b;
      OP_ADD, OP_ADDI: {carry_out, result} = sum;
      OP_SUB, OP_SUBI: {carry_out, result} = diff;
      OP_AND:          result = acc & b;
      OP_OR:           result = acc | b;
      default:         ;
    endcase
  end

endmodule

// File: rtl/mu02_core.sv
// mu02 multi-cycle accumulator CPU with req/ack memory port; all outputs are registered.
//   state    | meaning
//   ST_IDLE  | waiting for run
//   ST_FETCH | instruction read at pc outstanding
//   ST_EXEC  | executing ir; memory operand access outstanding for mem ops
//   ST_HALT  | stopped by STP or illegal opcode, left only by reset
module mu02_core
  import mu02_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 12,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              carry,
  output logic              halted,
  output logic              illegal
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic [3:0]        opcode;
  logic [3:0]        fetch_op;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] fetch_operand;
  logic [ADDR_W-1:0] exec_pc;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              ack;
  logic              jump_taken;

  assign opcode        = ir[DATA_W-1 -: 4];
  assign operand       = ir[ADDR_W-1:0];
  assign fetch_op      = mem_rdata[DATA_W-1 -: 4];
  assign fetch_operand = mem_rdata[ADDR_W-1:0];
  assign imm           = DATA_W'(sext(SEXT_W'(operand), ADDR_W));
  assign ack           = mem_req & mem_ack;

  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JGE:  jump_taken = ~acc[DATA_W-1];
      OP_JLT:  jump_taken = acc[DATA_W-1];
      OP_JNE:  jump_taken = |acc;
      default: jump_taken = 1'b0;
    endcase
    exec_pc = jump_taken ? operand : pc;
  end

  mu02_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (opcode),
    .acc       (acc),
    .mval      (mem_rdata),
    .imm       (imm),
    .carry_in  (carry),
    .result    (alu_result),
    .carry_out (alu_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= PC_INIT;
      acc       <= '0;
      ir        <= '0;
      carry     <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state    <= ST_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        ST_FETCH: begin
          if (ack) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(1);
            state <= ST_EXEC;
            // Operand access is decoded straight from the fetched word so it follows with no gap.
            if (is_mem_op(fetch_op)) begin
              mem_req   <= 1'b1;
              mem_we    <= (fetch_op == OP_STO);
              mem_addr  <= fetch_operand;
              mem_wdata <= acc;
            end else begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          if (is_mem_op(opcode)) begin
            if (ack) begin
              acc      <= alu_result;
              carry    <= alu_carry;
              state    <= ST_FETCH;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
            end
          end else if (opcode == OP_STP || is_illegal(opcode)) begin
            state   <= ST_HALT;
            halted  <= 1'b1;
            illegal <= is_illegal(opcode);
          end else begin
            acc      <= alu_result;
            carry    <= alu_carry;
            pc       <= exec_pc;
            state    <= ST_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= exec_pc;
          end
        end
        ST_HALT: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
